// File: rtl/datapath_pkg.sv
// Shared types and default parameters for the parameterised register datapath.
package datapath_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_NREGS   = 16;
  localparam int DEF_INIT_PC = 16;

endpackage

// File: rtl/datapath_if.sv
// Bundle of issue, operand, write-back and load-handshake signals of the datapath.
interface datapath_if #(
  parameter int XLEN = 32,
  parameter int AW   = 4
);
  logic            issue;
  logic            pc_inc;
  logic            jump;
  logic [AW-1:0]   rd_a, rd_b, rd_c, rd_d, mem_sel;
  logic            const_c;
  logic [XLEN-1:0] constant;
  logic [XLEN-1:0] op_a, op_b, op_c, op_d;
  logic [XLEN-1:0] alu_y1, alu_y2;
  logic [AW-1:0]   wa1, wa2;
  logic [1:0]      we;
  logic            cond;
  logic [7:0]      cmp_res;
  logic [2:0]      cmp_op;
  logic            ld;
  logic [AW-1:0]   ld_dst;
  logic            ld_req;
  logic [XLEN-1:0] ld_addr;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] mem_loca;
  logic            busy;
  logic [XLEN-1:0] program_counter;

  modport master (
    output issue, pc_inc, jump, rd_a, rd_b, rd_c, rd_d, mem_sel, const_c, constant,
           alu_y1, alu_y2, wa1, wa2, we, cond, cmp_res, cmp_op, ld, ld_dst,
           ld_valid, ld_data,
    input  op_a, op_b, op_c, op_d, ld_req, ld_addr, st_data, mem_loca, busy,
           program_counter
  );

  modport slave (
    input  issue, pc_inc, jump, rd_a, rd_b, rd_c, rd_d, mem_sel, const_c, constant,
           alu_y1, alu_y2, wa1, wa2, we, cond, cmp_res, cmp_op, ld, ld_dst,
           ld_valid, ld_data,
    output op_a, op_b, op_c, op_d, ld_req, ld_addr, st_data, mem_loca, busy,
           program_counter
  );
endinterface

// File: rtl/dp_regfile.sv
// Register file: five combinational read ports, two ALU write ports, a load
// write port and the PC increment path on register 0.
module dp_regfile #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int INIT_PC = 16,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 jump,
  input  logic [4:0][AW-1:0]   raddr,
  output logic [4:0][XLEN-1:0] rdata,
  input  logic                 fwd_en,
  input  logic [AW-1:0]        fwd_addr,
  input  logic [XLEN-1:0]      fwd_data,
  input  logic                 pc_inc,
  input  logic                 w1_en,
  input  logic [AW-1:0]        w1_addr,
  input  logic [XLEN-1:0]      w1_data,
  input  logic                 w2_en,
  input  logic [AW-1:0]        w2_addr,
  input  logic [XLEN-1:0]      w2_data,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [XLEN-1:0]      ld_data,
  output logic [XLEN-1:0]      pc
);

  logic [XLEN-1:0] regs [NREGS];

  // Register 0 reads as zero unless jump opens it; that gate also covers forwarded data.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      rdata[i] = regs[raddr[i]];
      if (fwd_en && raddr[i] == fwd_addr) rdata[i] = fwd_data;
      if (raddr[i] == '0 && !jump) rdata[i] = '0;
    end
  end

  // Later assignments win: the ALU ports override a coincident load, and Y1 overrides Y2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      regs[0] <= XLEN'(INIT_PC);
    end else begin
      if (ld_en)  regs[ld_addr] <= ld_data;
      if (pc_inc) regs[0]       <= regs[0] + XLEN'(1);
      if (w2_en)  regs[w2_addr] <= w2_data;
      if (w1_en)  regs[w1_addr] <= w1_data;
    end
  end

  assign pc = regs[0];

endmodule

// File: rtl/param_datapath.sv
// Datapath top: operand fetch, conditional write-back and a single outstanding load.
// Optional macro DATAPATH_BYPASS_EN forwards load data and releases busy in the ld_valid cycle.
module param_datapath
  import datapath_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREGS   = DEF_NREGS,
  parameter int INIT_PC = DEF_INIT_PC
) (
  input logic       clk,
  input logic       reset_n,
  datapath_if.slave dp
);

  localparam int AW = $clog2(NREGS);

  state_t               state, state_nxt;
  logic                 accept, ld_wr, fwd_en;
  logic                 y1_en, y2_en, pc_inc_en;
  logic [AW-1:0]        ld_dst_q;
  logic [4:0][AW-1:0]   raddr;
  logic [4:0][XLEN-1:0] rdata;
  logic [XLEN-1:0]      pc;

`ifdef DATAPATH_BYPASS_EN
  assign dp.busy = (state == LOAD_WAIT) && !dp.ld_valid;
  assign fwd_en  = ld_wr;
`else
  assign dp.busy = (state == LOAD_WAIT);
  assign fwd_en  = 1'b0;
`endif

  assign accept = dp.issue && !dp.busy;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_wr     = 1'b0;
    case (state)
      IDLE:      if (accept && dp.ld) state_nxt = LOAD_WAIT;
      LOAD_WAIT: if (dp.ld_valid) begin
        ld_wr     = 1'b1;
        state_nxt = (accept && dp.ld) ? LOAD_WAIT : IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // A load issue writes nothing itself; its result arrives through the load port.
  assign pc_inc_en = accept && dp.pc_inc;
  assign y1_en = accept && !dp.ld && dp.we[0] &&
                 (dp.cond ? dp.cmp_res[dp.cmp_op] : !(dp.pc_inc && dp.wa1 == '0));
  assign y2_en = accept && !dp.ld && !dp.cond && dp.we[1] &&
                 !(dp.pc_inc && dp.wa2 == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dp.ld_req  <= 1'b0;
      dp.ld_addr <= '0;
      ld_dst_q   <= '0;
    end else if (accept && dp.ld) begin
      dp.ld_req  <= 1'b1;
      dp.ld_addr <= rdata[4];
      ld_dst_q   <= dp.ld_dst;
    end else if (ld_wr) begin
      dp.ld_req  <= 1'b0;
    end
  end

  assign raddr = {dp.mem_sel, dp.rd_d, dp.rd_c, dp.rd_b, dp.rd_a};

  dp_regfile #(
    .XLEN(XLEN), .NREGS(NREGS), .INIT_PC(INIT_PC), .AW(AW)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .jump     (dp.jump),
    .raddr    (raddr),
    .rdata    (rdata),
    .fwd_en   (fwd_en),
    .fwd_addr (ld_dst_q),
    .fwd_data (dp.ld_data),
    .pc_inc   (pc_inc_en),
    .w1_en    (y1_en),
    .w1_addr  (dp.wa1),
    .w1_data  (dp.alu_y1),
    .w2_en    (y2_en),
    .w2_addr  (dp.wa2),
    .w2_data  (dp.alu_y2),
    .ld_en    (ld_wr),
    .ld_addr  (ld_dst_q),
    .ld_data  (dp.ld_data),
    .pc       (pc)
  );

  assign dp.op_a            = rdata[0];
  assign dp.op_b            = rdata[1];
  assign dp.op_c            = dp.const_c ? dp.constant : rdata[2];
  assign dp.op_d            = rdata[3];
  assign dp.st_data         = rdata[0];
  assign dp.mem_loca        = rdata[4];
  assign dp.program_counter = pc;

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath: a 32-bit instance for the main features and
// an 8-bit instance for PC wrap-around.
module tb_param_datapath;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  datapath_if #(.XLEN(32), .AW(4)) dp ();
  datapath_if #(.XLEN(8),  .AW(4)) sp ();

  param_datapath #(.XLEN(32), .NREGS(16), .INIT_PC(16)) dut (
    .clk(clk), .reset_n(reset_n), .dp(dp)
  );

  param_datapath #(.XLEN(8), .NREGS(16), .INIT_PC(16)) dut_small (
    .clk(clk), .reset_n(reset_n), .dp(sp)
  );

  task automatic clear_inputs();
    dp.issue = 0; dp.pc_inc = 0; dp.jump = 0; dp.rd_a = 0; dp.rd_b = 0; dp.rd_c = 0;
    dp.rd_d = 0; dp.mem_sel = 0; dp.const_c = 0; dp.constant = 0; dp.alu_y1 = 0;
    dp.alu_y2 = 0; dp.wa1 = 0; dp.wa2 = 0; dp.we = 0; dp.cond = 0; dp.cmp_res = 0;
    dp.cmp_op = 0; dp.ld = 0; dp.ld_dst = 0; dp.ld_valid = 0; dp.ld_data = 0;
    sp.issue = 0; sp.pc_inc = 0; sp.jump = 0; sp.rd_a = 0; sp.rd_b = 0; sp.rd_c = 0;
    sp.rd_d = 0; sp.mem_sel = 0; sp.const_c = 0; sp.constant = 0; sp.alu_y1 = 0;
    sp.alu_y2 = 0; sp.wa1 = 0; sp.wa2 = 0; sp.we = 0; sp.cond = 0; sp.cmp_res = 0;
    sp.cmp_op = 0; sp.ld = 0; sp.ld_dst = 0; sp.ld_valid = 0; sp.ld_data = 0;
  endtask

  // Steps across one rising edge, landing on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    dp.issue = 1; dp.we = 2'b01; dp.wa1 = addr; dp.alu_y1 = data;
    cycle();
    clear_inputs();
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] v);
    dp.jump = 1; dp.rd_d = addr;
    #1;
    v = dp.op_d;
  endtask

  task automatic test_reset();
    wr(4'd5, 32'h55);
    reset_n = 0;
    dp.issue = 1; dp.we = 2'b01; dp.wa1 = 4'd5; dp.alu_y1 = 32'h77; dp.pc_inc = 1;
    cycle();
    clear_inputs();
    reset_n = 1;
    dp.jump = 1; dp.rd_a = 4'd0; dp.rd_b = 4'd5;
    #1;
    total_cnt++;
    if (dp.op_a !== 32'd16) $display("[TB] FAIL reset_pc_read: got %h want %h", dp.op_a, 32'd16);
    else pass_cnt++;
    total_cnt++;
    if (dp.op_b !== 32'd0) $display("[TB] FAIL reset_reg5: got %h want %h", dp.op_b, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (dp.busy !== 1'b0 || dp.ld_req !== 1'b0 || dp.ld_addr !== 32'd0)
      $display("[TB] FAIL reset_ctrl: got busy=%b ld_req=%b ld_addr=%h want 0/0/0",
               dp.busy, dp.ld_req, dp.ld_addr);
    else pass_cnt++;
    dp.jump = 0;
    #1;
    total_cnt++;
    if (dp.op_a !== 32'd0) $display("[TB] FAIL r0_gated: got %h want %h", dp.op_a, 32'd0);
    else pass_cnt++;
  endtask

  task automatic test_dual_write();
    dp.issue = 1; dp.we = 2'b11; dp.wa1 = 4'd3; dp.wa2 = 4'd3;
    dp.alu_y1 = 32'hAA; dp.alu_y2 = 32'hBB;
    cycle();
    clear_inputs();
    read_reg(4'd3, rv);
    total_cnt++;
    if (rv !== 32'hAA) $display("[TB] FAIL y1_priority: got %h want %h", rv, 32'hAA);
    else pass_cnt++;
    dp.issue = 1; dp.we = 2'b11; dp.wa1 = 4'd8; dp.wa2 = 4'd9;
    dp.alu_y1 = 32'h11; dp.alu_y2 = 32'h22;
    cycle();
    clear_inputs();
    dp.jump = 1; dp.rd_a = 4'd9; dp.mem_sel = 4'd8; dp.rd_c = 4'd3; dp.const_c = 1;
    dp.constant = 32'h1234;
    #1;
    total_cnt++;
    if (dp.st_data !== 32'h22 || dp.mem_loca !== 32'h11)
      $display("[TB] FAIL dual_write: got st_data=%h mem_loca=%h want 22/11",
               dp.st_data, dp.mem_loca);
    else pass_cnt++;
    total_cnt++;
    if (dp.op_c !== 32'h1234) $display("[TB] FAIL op_c_const: got %h want %h", dp.op_c, 32'h1234);
    else pass_cnt++;
    dp.const_c = 0;
    #1;
    total_cnt++;
    if (dp.op_c !== 32'hAA) $display("[TB] FAIL op_c_reg: got %h want %h", dp.op_c, 32'hAA);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_cond_write();
    dp.issue = 1; dp.cond = 1; dp.cmp_op = 3'd2; dp.cmp_res = 8'h04; dp.we = 2'b11;
    dp.wa1 = 4'd7; dp.alu_y1 = 32'd5; dp.wa2 = 4'd10; dp.alu_y2 = 32'h77;
    cycle();
    clear_inputs();
    read_reg(4'd7, rv);
    total_cnt++;
    if (rv !== 32'd5) $display("[TB] FAIL cond_taken: got %h want %h", rv, 32'd5);
    else pass_cnt++;
    read_reg(4'd10, rv);
    total_cnt++;
    if (rv !== 32'd0) $display("[TB] FAIL cond_y2_taken: got %h want %h", rv, 32'd0);
    else pass_cnt++;
    clear_inputs();
    dp.issue = 1; dp.cond = 1; dp.cmp_op = 3'd2; dp.cmp_res = 8'h00; dp.we = 2'b11;
    dp.wa1 = 4'd7; dp.alu_y1 = 32'd9; dp.wa2 = 4'd10; dp.alu_y2 = 32'h66;
    cycle();
    clear_inputs();
    read_reg(4'd7, rv);
    total_cnt++;
    if (rv !== 32'd5) $display("[TB] FAIL cond_not_taken: got %h want %h", rv, 32'd5);
    else pass_cnt++;
    read_reg(4'd10, rv);
    total_cnt++;
    if (rv !== 32'd0) $display("[TB] FAIL cond_y2_not_taken: got %h want %h", rv, 32'd0);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_pc_inc();
    dp.issue = 1; dp.pc_inc = 1;
    cycle();
    clear_inputs();
    total_cnt++;
    if (dp.program_counter !== 32'd17) $display("[TB] FAIL pc_inc: got %h want %h", dp.program_counter, 32'd17);
    else pass_cnt++;
    dp.issue = 1; dp.pc_inc = 1; dp.we = 2'b11; dp.wa1 = 4'd0; dp.wa2 = 4'd0;
    dp.alu_y1 = 32'h99; dp.alu_y2 = 32'h88;
    cycle();
    clear_inputs();
    total_cnt++;
    if (dp.program_counter !== 32'd18) $display("[TB] FAIL pc_inc_vs_write: got %h want %h", dp.program_counter, 32'd18);
    else pass_cnt++;
    dp.issue = 0; dp.pc_inc = 1; dp.we = 2'b01; dp.wa1 = 4'd11; dp.alu_y1 = 32'h5A;
    cycle();
    clear_inputs();
    read_reg(4'd11, rv);
    total_cnt++;
    if (rv !== 32'd0 || dp.program_counter !== 32'd18)
      $display("[TB] FAIL no_issue: got reg11=%h pc=%h want 0/18", rv, dp.program_counter);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_load();
    wr(4'd2, 32'h100);
    dp.issue = 1; dp.ld = 1; dp.mem_sel = 4'd2; dp.ld_dst = 4'd4;
    dp.we = 2'b01; dp.wa1 = 4'd6; dp.alu_y1 = 32'h33;
    cycle();
    clear_inputs();
    #1;
    total_cnt++;
    if (dp.ld_req !== 1'b1 || dp.ld_addr !== 32'h100 || dp.busy !== 1'b1)
      $display("[TB] FAIL load_start: got ld_req=%b ld_addr=%h busy=%b want 1/100/1",
               dp.ld_req, dp.ld_addr, dp.busy);
    else pass_cnt++;
    dp.issue = 1; dp.pc_inc = 1; dp.we = 2'b01; dp.wa1 = 4'd12; dp.alu_y1 = 32'h44;
    cycle();
    clear_inputs();
    cycle();
    dp.ld_valid = 1; dp.ld_data = 32'hDEAD; dp.rd_a = 4'd4; dp.jump = 1;
    #1;
`ifdef DATAPATH_BYPASS_EN
    total_cnt++;
    if (dp.op_a !== 32'hDEAD || dp.busy !== 1'b0)
      $display("[TB] FAIL load_bypass: got op_a=%h busy=%b want dead/0", dp.op_a, dp.busy);
    else pass_cnt++;
`else
    total_cnt++;
    if (dp.op_a !== 32'h0 || dp.busy !== 1'b1)
      $display("[TB] FAIL load_no_bypass: got op_a=%h busy=%b want 0/1", dp.op_a, dp.busy);
    else pass_cnt++;
`endif
    total_cnt++;
    if (dp.ld_req !== 1'b1) $display("[TB] FAIL ld_req_hold: got %b want 1", dp.ld_req);
    else pass_cnt++;
    cycle();
    clear_inputs();
    total_cnt++;
    if (dp.ld_req !== 1'b0 || dp.busy !== 1'b0 || dp.program_counter !== 32'd18)
      $display("[TB] FAIL load_end: got ld_req=%b busy=%b pc=%h want 0/0/18",
               dp.ld_req, dp.busy, dp.program_counter);
    else pass_cnt++;
    read_reg(4'd4, rv);
    total_cnt++;
    if (rv !== 32'hDEAD) $display("[TB] FAIL load_data: got %h want %h", rv, 32'hDEAD);
    else pass_cnt++;
    read_reg(4'd6, rv);
    total_cnt++;
    if (rv !== 32'd0) $display("[TB] FAIL load_no_y1: got %h want %h", rv, 32'd0);
    else pass_cnt++;
    read_reg(4'd12, rv);
    total_cnt++;
    if (rv !== 32'd0) $display("[TB] FAIL stall_issue: got %h want %h", rv, 32'd0);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_ld_valid_idle();
    dp.ld_valid = 1; dp.ld_data = 32'h1234;
    cycle();
    clear_inputs();
    read_reg(4'd4, rv);
    total_cnt++;
    if (rv !== 32'hDEAD || dp.ld_req !== 1'b0)
      $display("[TB] FAIL ld_valid_idle: got reg4=%h ld_req=%b want dead/0", rv, dp.ld_req);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_indirect_jump();
    dp.issue = 1; dp.ld = 1; dp.mem_sel = 4'd2; dp.ld_dst = 4'd0;
    cycle();
    clear_inputs();
    dp.ld_valid = 1; dp.ld_data = 32'h40; dp.rd_b = 4'd0;
    #1;
    total_cnt++;
    if (dp.op_b !== 32'd0) $display("[TB] FAIL jump_gate_fwd: got %h want %h", dp.op_b, 32'd0);
    else pass_cnt++;
    cycle();
    clear_inputs();
    total_cnt++;
    if (dp.program_counter !== 32'h40) $display("[TB] FAIL indirect_jump: got %h want %h", dp.program_counter, 32'h40);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    dp.issue = 1; dp.ld = 1; dp.mem_sel = 4'd2; dp.ld_dst = 4'd4;
    cycle();
    clear_inputs();
    reset_n = 0;
    cycle();
    reset_n = 1;
    #1;
    total_cnt++;
    if (dp.ld_req !== 1'b0 || dp.busy !== 1'b0)
      $display("[TB] FAIL reset_mid_load: got ld_req=%b busy=%b want 0/0", dp.ld_req, dp.busy);
    else pass_cnt++;
    dp.ld_valid = 1; dp.ld_data = 32'hBEEF;
    cycle();
    clear_inputs();
    read_reg(4'd4, rv);
    total_cnt++;
    if (rv !== 32'd0) $display("[TB] FAIL stale_ld_valid: got %h want %h", rv, 32'd0);
    else pass_cnt++;
    clear_inputs();
    wr(4'd5, 32'd5);
    read_reg(4'd5, rv);
    total_cnt++;
    if (rv !== 32'd5) $display("[TB] FAIL issue_after_reset: got %h want %h", rv, 32'd5);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_pc_wrap();
    sp.issue = 1; sp.we = 2'b01; sp.wa1 = 4'd0; sp.alu_y1 = 8'hFF;
    cycle();
    clear_inputs();
    total_cnt++;
    if (sp.program_counter !== 8'hFF) $display("[TB] FAIL pc_set_ff: got %h want %h", sp.program_counter, 8'hFF);
    else pass_cnt++;
    sp.issue = 1; sp.pc_inc = 1;
    cycle();
    clear_inputs();
    total_cnt++;
    if (sp.program_counter !== 8'h00) $display("[TB] FAIL pc_wrap: got %h want %h", sp.program_counter, 8'h00);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    cycle();
    reset_n = 1;
    test_reset();
    test_dual_write();
    test_cond_write();
    test_pc_inc();
    test_load();
    test_ld_valid_idle();
    test_indirect_jump();
    test_reset_mid_load();
    test_pc_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
